sdsg_delay_cal: RTL
===================

Name: sdsg_delay_cal

Overview:
- Upstream controller for the selectable-delay shift line. It owns the line's tap select and input signal.
- In normal operation it passes a software tap setting straight through to the line.
- On a start pulse it runs a self-test sweep over every tap from 0 to max_tap_i:
  - injects a single-cycle probe into the line;
  - times the echo returning on the line output;
  - checks each tap delays by exactly tap+1 cycles.
- Reports pass/fail, the first failing tap and the measured latency. Restores the operational tap when finished.

Parameters:
- DEPTH, 256, length of the downstream delay line; the flush phase lasts DEPTH cycles.
- TIMEOUT, 300, echo wait limit in cycles. Must exceed DEPTH+1. The counter is 9 bits, so TIMEOUT ≤ 511.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- cfg_tap_i  in  8  operational tap, forwarded when not calibrating
- max_tap_i  in  8  last tap to test, inclusive; sampled at start
- start_i  in  1  start calibration; accepted only in IDLE
- busy_o  out  1  high from the cycle after start until done
- done_o  out  1  one-cycle pulse at the end of calibration
- pass_o  out  1  result of the last run; held until the next start
- fail_tap_o  out  8  first failing tap; 0 if passed
- meas_lat_o  out  9  measured latency at the failing tap; 0 on pass; 9'h1FF on timeout
- delay_num_o  out  8  to the line's tap-select input; registered
- probe_o  out  1  to the line's signal input; registered
- echo_i  in  1  from the line's output; combinational tap of its register

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - state=IDLE; busy_o=0, done_o=0, pass_o=0, fail_tap_o=0, meas_lat_o=0, delay_num_o=0, probe_o=0.
  - Internal tap and counter registers clear to 0.
  - Reset asserted mid-run aborts immediately. The run is not resumed after reset release.
- All outputs are registered. echo_i is used only as a comparison input; no combinational path to any output.
- State machine:
  - IDLE:
    - delay_num_o <= cfg_tap_i every cycle; probe_o=0.
    - On start_i: latch max_tap_i; tap <= 0; cnt <= 0; busy_o <= 1; pass_o <= 0; go to FLUSH.
  - FLUSH:
    - probe_o=0, delay_num_o=tap; cnt increments each cycle.
    - When cnt==DEPTH-1: cnt <= 0, go to PULSE. This guarantees the line is empty.
  - PULSE: probe_o <= 1 for exactly one cycle; cnt <= 0; go to WAIT.
  - WAIT:
    - probe_o=0; cnt increments each cycle.
    - Counting convention: the cycle probe_o is high is cycle 0.
    - On the first cycle echo_i==1: latency L = that cycle's index. Go to CHECK.
    - If cnt reaches TIMEOUT with no echo: L = 9'h1FF; go to CHECK.
  - CHECK:
    - Expected latency is tap+1 (tap 0 → 1 cycle).
    - Mismatch or timeout: fail_tap_o <= tap; meas_lat_o <= L; pass_o <= 0; go to DONE.
    - Match and tap==latched max: pass_o <= 1; fail_tap_o <= 0; meas_lat_o <= 0; go to DONE.
    - Match otherwise: tap <= tap+1; cnt <= 0; go to FLUSH.
  - DONE: done_o=1 for one cycle; busy_o <= 0; delay_num_o <= cfg_tap_i; go to IDLE.
- Boundary conditions:
  - start_i while busy is ignored.
  - Start and done coincide only at IDLE re-entry. start_i in the first IDLE cycle after DONE is accepted normally.
  - max_tap_i=255: tap 255 is the last; no 8-bit wrap is performed.
  - max_tap_i=0: exactly one iteration.
  - echo_i high during FLUSH is ignored, and the line is flushed anyway.
  - Changing cfg_tap_i during a run has no effect until DONE.

Decomposition:
- Shared package holds:
  - state enum: IDLE, FLUSH, PULSE, WAIT, CHECK, DONE;
  - LAT_TIMEOUT_CODE = 9'h1FF;
  - TAP_W = 8, CNT_W = 9.
- Single module, no sub-module. The bench instantiates the real delay-line block as the DUT load.

Test Plan:
- Reset mid-WAIT at tap 17 → all outputs 0 and state IDLE in the same cycle; after release, delay_num_o follows cfg_tap_i=5 on the next edge.
- Idle pass-through: cfg_tap_i=42, no start → delay_num_o=42 one cycle later; probe_o stays 0.
- Full sweep with a correct delay line (DEPTH=256), max_tap_i=255 → done_o pulses once; pass_o=1, fail_tap_o=0, meas_lat_o=0; busy_o low after done.
- Line model with tap 9 stuck to tap 10 → pass_o=0, fail_tap_o=9, meas_lat_o=11.
- Echo forced 0 at tap 3 → after TIMEOUT cycles in WAIT: pass_o=0, fail_tap_o=3, meas_lat_o=0x1FF.
- start_i pulsed again while busy; separately max_tap_i=0 → second start ignored; the single-tap run takes DEPTH+1+1+1 cycles to CHECK, then pass_o=1.

Source files
------------

// File: rtl/sdsg_delay_cal_pkg.sv
// Shared types and constants for the delay-line calibration controller.
package sdsg_delay_cal_pkg;

  localparam int TAP_W = 8;
  localparam int CNT_W = 9;

  // Latency code reported when the echo never returned.
  localparam logic [CNT_W-1:0] LAT_TIMEOUT_CODE = 9'h1FF;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    PULSE = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sdsg_delay_cal.sv
// Calibration controller for the selectable-delay shift line. In idle it
// forwards the operational tap; on start it sweeps taps 0..max, injects a
// single probe per tap and checks that the echo returns after tap+1 cycles.
module sdsg_delay_cal
  import sdsg_delay_cal_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int TIMEOUT = 300
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [TAP_W-1:0] cfg_tap_i,
  input  logic [TAP_W-1:0] max_tap_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [TAP_W-1:0] fail_tap_o,
  output logic [CNT_W-1:0] meas_lat_o,
  output logic [TAP_W-1:0] delay_num_o,
  output logic             probe_o,
  input  logic             echo_i
);

  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(TIMEOUT);

  state_e           state_reg;
  logic [TAP_W-1:0] tap_reg;
  logic [TAP_W-1:0] max_tap_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] lat_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             pass_reg;
  logic [TAP_W-1:0] fail_tap_reg;
  logic [CNT_W-1:0] meas_lat_reg;
  logic [TAP_W-1:0] delay_num_reg;
  logic             probe_reg;

  // Latency the line should show at the current tap (tap 0 -> 1 cycle).
  logic [CNT_W-1:0] exp_lat;
  assign exp_lat = {1'b0, tap_reg} + CNT_W'(1);

  // Calibration sequencer; every output comes straight from a register here.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      tap_reg       <= '0;
      max_tap_reg   <= '0;
      cnt_reg       <= '0;
      lat_reg       <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      pass_reg      <= 1'b0;
      fail_tap_reg  <= '0;
      meas_lat_reg  <= '0;
      delay_num_reg <= '0;
      probe_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          probe_reg     <= 1'b0;
          done_reg      <= 1'b0;
          delay_num_reg <= cfg_tap_i;
          if (start_i) begin
            max_tap_reg   <= max_tap_i;
            tap_reg       <= '0;
            cnt_reg       <= '0;
            busy_reg      <= 1'b1;
            pass_reg      <= 1'b0;
            delay_num_reg <= '0;
            state_reg     <= FLUSH;
          end
        end

        // Hold the probe low long enough that nothing from the previous
        // tap can still be inside the line; echoes seen here are ignored.
        FLUSH: begin
          probe_reg <= 1'b0;
          if (cnt_reg == FLUSH_LAST) begin
            cnt_reg   <= '0;
            state_reg <= PULSE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        // The cycle probe_o is high is latency index 0 (first WAIT cycle).
        PULSE: begin
          probe_reg <= 1'b1;
          cnt_reg   <= '0;
          state_reg <= WAIT;
        end

        WAIT: begin
          probe_reg <= 1'b0;
          if (echo_i) begin
            lat_reg   <= cnt_reg;
            state_reg <= CHECK;
          end else if (cnt_reg == WAIT_LIMIT) begin
            lat_reg   <= LAT_TIMEOUT_CODE;
            state_reg <= CHECK;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        // The timeout code can never equal tap+1, so it lands in the fail arm.
        CHECK: begin
          if (lat_reg != exp_lat) begin
            fail_tap_reg <= tap_reg;
            meas_lat_reg <= lat_reg;
            pass_reg     <= 1'b0;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else if (tap_reg == max_tap_reg) begin
            fail_tap_reg <= '0;
            meas_lat_reg <= '0;
            pass_reg     <= 1'b1;
            done_reg     <= 1'b1;
            state_reg    <= DONE;
          end else begin
            tap_reg       <= tap_reg + TAP_W'(1);
            delay_num_reg <= tap_reg + TAP_W'(1);
            cnt_reg       <= '0;
            state_reg     <= FLUSH;
          end
        end

        DONE: begin
          done_reg      <= 1'b0;
          busy_reg      <= 1'b0;
          delay_num_reg <= cfg_tap_i;
          state_reg     <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign pass_o      = pass_reg;
  assign fail_tap_o  = fail_tap_reg;
  assign meas_lat_o  = meas_lat_reg;
  assign delay_num_o = delay_num_reg;
  assign probe_o     = probe_reg;

endmodule
